// File: rtl/mem_bus_interface.sv
`timescale 1ns/1ps
// Memory-side endpoint of the 32-bit datapath bus.
// Captures address/data from BusMuxOut into MAR/MDR, runs a req/ack
// transaction with word-addressed RAM (with timeout), and returns read data
// via MDR onto BusMuxInMDR.
//
// Ports:
//   clock, clear      : clock and synchronous active-high reset
//   BusMuxOut         : datapath bus value
//   MARin, MDRin      : load MAR / MDR from bus (IDLE or FINISH only)
//   MemRead, MemWrite : one-cycle transaction strobes (read has priority)
//   BusMuxInMDR       : MDR contents to bus mux
//   mem_addr          : MAR contents to RAM
//   mem_wdata         : MDR contents to RAM
//   mem_rd, mem_wr    : request, held until ack or timeout
//   mem_rdata,mem_ack : RAM read data and one-cycle acknowledge
//   mem_busy          : transaction in progress
//   mem_done, mem_err : one-cycle completion / timeout pulses
module mem_bus_interface #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] BusMuxInMDR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic                mem_busy_q, mem_busy_d;
    logic                mem_done_q, mem_done_d;
    logic                mem_err_q, mem_err_d;
    logic                timeout_hit;

    // Last waiting cycle: counter has reached TIMEOUT-1 with the request still up
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and registered-output logic; outputs reflect the state being entered
    always_comb begin
        state_d    = state_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        cnt_d      = cnt_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_busy_d = 1'b0;
        mem_done_d = 1'b0;
        mem_err_d  = 1'b0;

        case (state_q)
            // FINISH behaves like IDLE so back-to-back commands are accepted
            S_IDLE, S_FINISH: begin
                if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
                if (MDRin) mdr_d = BusMuxOut;
                cnt_d = '0;
                if (MemRead) begin
                    state_d    = S_READ;
                    mem_rd_d   = 1'b1;
                    mem_busy_d = 1'b1;
                end else if (MemWrite) begin
                    state_d    = S_WRITE;
                    mem_wr_d   = 1'b1;
                    mem_busy_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            // Ack wins over a coincident timeout
            S_READ: begin
                if (mem_ack) begin
                    mdr_d      = mem_rdata;
                    state_d    = S_FINISH;
                    mem_done_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = S_FINISH;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_rd_d   = 1'b1;
                    mem_busy_d = 1'b1;
                end
            end

            S_WRITE: begin
                if (mem_ack) begin
                    state_d    = S_FINISH;
                    mem_done_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = S_FINISH;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_wr_d   = 1'b1;
                    mem_busy_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; clear aborts any request in flight silently
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= S_IDLE;
            mar_q      <= '0;
            mdr_q      <= '0;
            cnt_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_busy_q <= 1'b0;
            mem_done_q <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            cnt_q      <= cnt_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_busy_q <= mem_busy_d;
            mem_done_q <= mem_done_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign BusMuxInMDR = mdr_q;
    assign mem_wdata   = mdr_q;
    assign mem_addr    = mar_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_busy    = mem_busy_q;
    assign mem_done    = mem_done_q;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_bus_interface: a driver issues loads and
// transactions and pushes the expected outcome; a monitor pops and compares
// whenever the DUT pulses mem_done or mem_err.
module tb_mem_bus_interface;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clock;
    logic              clear;
    logic [DATA_W-1:0] BusMuxOut;
    logic              MARin;
    logic              MDRin;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] BusMuxInMDR;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_err;

    mem_bus_interface #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .BusMuxOut  (BusMuxOut),
        .MARin      (MARin),
        .MDRin      (MDRin),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .BusMuxInMDR(BusMuxInMDR),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_err    (mem_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit                is_read;
        bit                is_write;
        bit                err;
        int                cycles;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] mdr;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Reference view of the architectural registers
    logic [ADDR_W-1:0] m_mar;
    logic [DATA_W-1:0] m_mdr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- monitor ----------------
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    exp_t cur;

    always @(negedge clock) begin
        if (clear) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_rd) rd_cnt++;
            if (mem_wr) wr_cnt++;
            if (mem_wr && exp_q.size() > 0) begin
                check("wr_wdata", mem_wdata, exp_q[0].mdr);
                check("wr_addr", 32'(mem_addr), 32'(exp_q[0].addr));
            end
            if (mem_done || mem_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", {30'd0, mem_done, mem_err}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("done", 32'(mem_done), 32'(!cur.err));
                    check("err", 32'(mem_err), 32'(cur.err));
                    check("busy_at_end", 32'(mem_busy), 32'd0);
                    check("rd_cycles", 32'(rd_cnt), cur.is_read ? 32'(cur.cycles) : 32'd0);
                    check("wr_cycles", 32'(wr_cnt), cur.is_write ? 32'(cur.cycles) : 32'd0);
                    check("mdr", BusMuxInMDR, cur.mdr);
                    check("wdata", mem_wdata, cur.mdr);
                    check("addr", 32'(mem_addr), 32'(cur.addr));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle_inputs();
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        mem_ack  = 1'b0;
    endtask

    // Optional MAR/MDR loads, then a strobe; ack_n > TIMEOUT means no ack.
    task automatic do_txn(input bit ld_mar, input logic [31:0] mar_bus,
                          input bit ld_mdr, input logic [31:0] mdr_bus,
                          input bit rd, input bit wr, input int ack_n,
                          input logic [31:0] rdata, input bit garbage);
        exp_t e;
        int   end_n;
        if (ld_mar) begin
            BusMuxOut = mar_bus;
            MARin     = 1'b1;
            tick();
            MARin = 1'b0;
            m_mar = mar_bus[ADDR_W-1:0];
        end
        if (ld_mdr) begin
            BusMuxOut = mdr_bus;
            MDRin     = 1'b1;
            tick();
            MDRin = 1'b0;
            m_mdr = mdr_bus;
        end
        if (!(rd || wr)) return;
        e.is_read  = rd;
        e.is_write = !rd && wr;
        e.err      = (ack_n > TIMEOUT);
        end_n      = e.err ? TIMEOUT : ack_n;
        e.cycles   = end_n;
        e.addr     = m_mar;
        if (rd && !e.err) m_mdr = rdata;
        e.mdr      = m_mdr;
        exp_q.push_back(e);
        MemRead  = rd;
        MemWrite = wr;
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        for (int i = 1; i <= end_n; i++) begin
            mem_ack   = (i == ack_n);
            mem_rdata = (i == ack_n) ? rdata : $urandom;
            if (garbage) begin
                BusMuxOut = $urandom;
                MARin     = 1'($urandom_range(0, 1));
                MDRin     = 1'($urandom_range(0, 1));
                MemRead   = 1'($urandom_range(0, 1));
                MemWrite  = 1'($urandom_range(0, 1));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset with garbage on every input
        clear     = 1'b1;
        BusMuxOut = 32'hDEAD_BEEF;
        MARin     = 1'b1;
        MDRin     = 1'b1;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5_A5A5;
        m_mar     = '0;
        m_mdr     = '0;
        tick();
        tick();
        check("rst_mdr", BusMuxInMDR, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_ctrl", {27'd0, mem_rd, mem_wr, mem_busy, mem_done, mem_err}, 32'd0);
        clear = 1'b0;
        idle_inputs();
        tick();
        check("post_rst_ctrl", {27'd0, mem_rd, mem_wr, mem_busy, mem_done, mem_err}, 32'd0);

        // Write 0x11116666 to 0x055, ack after 3 cycles; then read back with immediate ack
        do_txn(1, 32'h0000_0055, 1, 32'h1111_6666, 0, 1, 3, 32'h0, 0);
        do_txn(0, 32'h0, 0, 32'h0, 1, 0, 1, 32'h1111_6666, 0);
        tick();

        // Read timeout: MDR keeps preloaded value
        do_txn(0, 32'h0, 1, 32'h3333_8888, 1, 0, TIMEOUT + 5, 32'h0, 0);
        tick();

        // Commands during READ are ignored
        do_txn(0, 32'h0, 0, 32'h0, 1, 0, 6, 32'hCAFE_0001, 1);
        tick();

        // Simultaneous read+write strobe -> read only
        do_txn(1, 32'h0000_0123, 0, 32'h0, 1, 1, 2, 32'h0BAD_F00D, 0);

        // Ack coincident with timeout -> done
        do_txn(0, 32'h0, 0, 32'h0, 1, 0, TIMEOUT, 32'h7777_0000, 0);
        do_txn(0, 32'h0, 0, 32'h0, 0, 1, TIMEOUT, 32'h0, 0);

        // Back-to-back reads: second strobe lands in FINISH
        do_txn(0, 32'h0, 0, 32'h0, 1, 0, 2, 32'h1234_5678, 0);
        do_txn(0, 32'h0, 0, 32'h0, 1, 0, 1, 32'h8765_4321, 0);
        tick();

        // clear during a write: no completion, registers zeroed, late ack ignored
        BusMuxOut = 32'h0000_01AB;
        MARin     = 1'b1;
        tick();
        MARin     = 1'b0;
        BusMuxOut = 32'h5555_AAAA;
        MDRin     = 1'b1;
        tick();
        MDRin    = 1'b0;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        check("midwr_active", 32'(mem_wr), 32'd1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_mar = '0;
        m_mdr = '0;
        check("midwr_ctrl", {27'd0, mem_rd, mem_wr, mem_busy, mem_done, mem_err}, 32'd0);
        check("midwr_addr", 32'(mem_addr), 32'd0);
        check("midwr_mdr", BusMuxInMDR, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("late_ack_ctrl", {27'd0, mem_rd, mem_wr, mem_busy, mem_done, mem_err}, 32'd0);
        tick();
        check("late_ack_ctrl2", {27'd0, mem_rd, mem_wr, mem_busy, mem_done, mem_err}, 32'd0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int kind;
            bit rd;
            bit wr;
            kind = int'($urandom_range(0, 3));
            rd   = (kind == 0) || (kind == 2) || (kind == 3);
            wr   = (kind == 1) || (kind == 2);
            do_txn(1'($urandom_range(0, 1)), $urandom,
                   1'($urandom_range(0, 1)), $urandom,
                   rd, wr, int'($urandom_range(1, TIMEOUT + 4)),
                   $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Every issued transaction must have completed
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Memory-side endpoint of the processor's 32-bit datapath bus. It captures addresses and write data from BusMuxOut into MAR/MDR, runs a request/acknowledge transaction with the word-addressed RAM, and returns read data through MDR to the bus-mux input BusMuxInMDR. It sits between the bus, the control unit (which issues MARin/MDRin/MemRead/MemWrite) and the memory array.

## Interface
- DATA_W, 32, bus and memory word width
- ADDR_W, 9, memory address width; MAR holds BusMuxOut[ADDR_W-1:0]
- TIMEOUT, 15, cycles to wait for mem_ack before aborting (1..255)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- clear  in  1  reset; synchronous and active-high
- BusMuxOut  in  DATA_W  datapath bus value
- MARin  in  1  load MAR from bus
- MDRin  in  1  load MDR from bus
- MemRead  in  1  start read strobe (one cycle from control unit)
- MemWrite  in  1  start write strobe
- BusMuxInMDR  out  DATA_W  MDR contents, to bus mux
- mem_addr  out  ADDR_W  MAR contents, to RAM
- mem_wdata  out  DATA_W  MDR contents, to RAM
- mem_rd  out  1  read request, held until ack/timeout
- mem_wr  out  1  write request, held until ack/timeout
- mem_rdata  in  DATA_W  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM acknowledge, one cycle
- mem_busy  out  1  transaction in progress
- mem_done  out  1  one-cycle pulse: transaction completed
- mem_err  out  1  one-cycle pulse: transaction timed out

## Operation
- States: IDLE, READ, WRITE, FINISH.
- IDLE: MARin loads MAR; MDRin loads MDR; both may occur together. MemRead -> READ; MemWrite -> WRITE; both together -> READ (read priority, write dropped). mem_ack in IDLE ignored.
- READ: mem_rd=1, mem_addr=MAR. On mem_ack: MDR <= mem_rdata, go FINISH with done. Timeout: go FINISH with err; MDR unchanged.
- WRITE: mem_wr=1, mem_wdata=MDR. On mem_ack go FINISH with done; on timeout go FINISH with err.
- FINISH: exactly one cycle; mem_done or mem_err high (never both); mem_busy=0; then IDLE. MARin/MDRin/MemRead/MemWrite accepted in FINISH as in IDLE (back-to-back transactions).
- mem_busy=1 in READ and WRITE only. In those states MARin, MDRin, MemRead, MemWrite are ignored; MAR and MDR are frozen except for the read-data capture.
- Timeout counter: cleared on entry to READ/WRITE and increments each cycle there without ack. When the counter reaches TIMEOUT-1 with no ack in that cycle, abort. An ack in the same cycle as the timeout wins, giving done rather than err.
- BusMuxInMDR, mem_wdata = MDR; mem_addr = MAR. All are registered and continuously driven. Bus tristating is not part of this block; the bus mux selects via MDRout.
- clear: state IDLE; MAR=0; MDR=0; counter=0. All outputs 0, including any request in flight, which aborts with no done or err. clear overrides every other input in the same cycle.

## Timing
- Command at edge k -> mem_rd/mem_wr high from k. mem_ack sampled at edge k+n (n>=1) -> request low and done high from k+n; back to IDLE at k+n+1.
- Minimum transaction is 2 cycles from strobe to IDLE. Read data is visible on BusMuxInMDR in the same cycle that mem_done is high.
- With no ack: request held for exactly TIMEOUT cycles, then mem_err for 1 cycle.
- MARin/MDRin load latency is 1 edge. Bus value at edge k appears on mem_addr/BusMuxInMDR after k.

## Test plan
- Reset: drive garbage and clear=1 for 2 cycles -> all outputs 0, state IDLE.
- Write then read: MARin with bus=0x0000_0055, then MDRin with bus=0x1111_6666, then MemWrite, ack after 3 cycles -> mem_addr=0x055, mem_wdata=0x11116666, mem_wr high 3 cycles, mem_done one pulse. Then MemRead with mem_rdata=0x1111_6666 and immediate ack -> BusMuxInMDR=0x11116666 two cycles after the strobe.
- Timeout: TIMEOUT=15, MemRead, no ack -> mem_rd high exactly 15 cycles, mem_err one pulse, MDR unchanged (0x3333_8888 preloaded).
- Ignored commands while busy: during READ, pulse MARin with bus=0x1FF, MDRin, and MemWrite -> MAR and MDR unchanged, no second transaction; ack then completes the original read.
- Simultaneous: MemRead+MemWrite in IDLE -> only mem_rd asserts. Ack and timeout in the same cycle -> mem_done, no mem_err. Back-to-back MemRead issued in FINISH -> new request on the next cycle.
- clear mid-WRITE: at cycle 2 of a write, clear=1 -> mem_wr=0 next cycle, no done/err, MAR=MDR=0, and a later ack is ignored.
